// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module     : sram_ctrl_pkg
// Description: Shared opcodes, burst-length width and FSM state encoding for
//              the SRAM byte-serial command front end.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
package sram_ctrl_pkg;

   // Burst length field width: opcode[3:0] holds (burst count - 1)
   localparam int LEN_W = 4;

   // Opcode field, cmd_byte[7:6]
   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_RD  = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      WDATA    = 3'd2,
      RD_ISSUE = 3'd3,
      RD_WAIT  = 3'd4,
      RESP     = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_cmd_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module     : sram_cmd_ctrl
// Description: Byte-serial command front end for an SRAM core. Decodes
//              opcode/address/data bytes, issues registered single-cycle
//              read/write strobes with address auto-increment (bursts of
//              1..16) and returns read bytes over a valid/ready response.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
module sram_cmd_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 6,
   parameter int READ_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [7:0]        cmd_byte_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [7:0]        rsp_data_o,
   output logic              busy_o,
   output logic              err_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   input  logic [7:0]        mem_rdata_i
);

   // Read-wait countdown start value; the 2-bit counter covers READ_LAT 1..4
   localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

   state_t             state_q,     state_d;
   logic [1:0]         op_q,        op_d;
   logic [LEN_W-1:0]   rem_q,       rem_d;
   logic [ADDR_W-1:0]  addr_q,      addr_d;
   logic [1:0]         lat_q,       lat_d;
   logic [7:0]         rdata_q,     rdata_d;
   logic               err_q,       err_d;
   logic               mem_en_q,    mem_en_d;
   logic               mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
   logic [7:0]         mem_wdata_q, mem_wdata_d;

   logic               cmd_fire;
   logic               rsp_fire;

   // Host bytes are only taken in the command-phase states, never during reset
   assign cmd_ready_o = rst_ni &&
                        ((state_q == IDLE) || (state_q == ADDR) || (state_q == WDATA));
   assign cmd_fire    = cmd_valid_i && cmd_ready_o;
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_fire    = rsp_valid_o && rsp_ready_i;
   assign rsp_data_o  = rdata_q;
   assign err_o       = err_q;
   // A write's last strobe lands after the FSM has already returned to IDLE
   assign busy_o      = (state_q != IDLE) || mem_en_q;
   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

   // State and datapath registers; reset discards any in-flight read
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         op_q        <= OP_NOP;
         rem_q       <= '0;
         addr_q      <= '0;
         lat_q       <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rem_q       <= rem_d;
         addr_q      <= addr_d;
         lat_q       <= lat_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Next-state, burst bookkeeping and SRAM strobe generation
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      rem_d       = rem_q;
      addr_d      = addr_q;
      lat_d       = lat_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               case (cmd_byte_i[7:6])
                  OP_WR, OP_RD: begin
                     op_d    = cmd_byte_i[7:6];
                     rem_d   = cmd_byte_i[LEN_W-1:0];
                     state_d = ADDR;
                  end
                  OP_RSV:  err_d = 1'b1;
                  default: ;
               endcase
            end
         end

         ADDR: begin
            if (cmd_fire) begin
               addr_d  = cmd_byte_i[ADDR_W-1:0];
               state_d = (op_q == OP_WR) ? WDATA : RD_ISSUE;
            end
         end

         WDATA: begin
            if (cmd_fire) begin
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = cmd_byte_i;
               addr_d      = addr_q + ADDR_W'(1);
               if (rem_q == '0) begin
                  state_d = IDLE;
               end else begin
                  rem_d = rem_q - LEN_W'(1);
               end
            end
         end

         RD_ISSUE: begin
            mem_en_d   = 1'b1;
            mem_addr_d = addr_q;
            lat_d      = LAT_M1;
            state_d    = RD_WAIT;
         end

         RD_WAIT: begin
            // The first RD_WAIT cycle is the strobe cycle itself; countdown starts after it
            if (!mem_en_q) begin
               if (lat_q == 2'd0) begin
                  rdata_d = mem_rdata_i;
                  state_d = RESP;
               end else begin
                  lat_d = lat_q - 2'd1;
               end
            end
         end

         RESP: begin
            if (rsp_fire) begin
               if (rem_q != '0) begin
                  rem_d   = rem_q - LEN_W'(1);
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = RD_ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_cmd_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module     : tb_sram_cmd_ctrl
// Description: Self-checking bench for sram_cmd_ctrl with behavioural SRAM
//              models (READ_LAT=1 main instance, READ_LAT=3 second instance).
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_sram_cmd_ctrl;

   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   always #5 clk = ~clk;

   // Main instance, READ_LAT = 1
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [7:0]    cmd_byte = 8'h00;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [7:0]    rsp_data;
   logic          busy, err, mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata, mem_rdata;

   // Second instance, READ_LAT = 3
   logic          b_cmd_valid = 1'b0;
   logic          b_cmd_ready;
   logic [7:0]    b_cmd_byte = 8'h00;
   logic          b_rsp_valid;
   logic          b_rsp_ready = 1'b0;
   logic [7:0]    b_rsp_data;
   logic          b_busy, b_err, b_mem_en, b_mem_we;
   logic [AW-1:0] b_mem_addr;
   logic [7:0]    b_mem_wdata, b_mem_rdata;

   sram_cmd_ctrl #(.ADDR_W(AW), .READ_LAT(1)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_byte_i(cmd_byte),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
      .busy_o(busy), .err_o(err),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   sram_cmd_ctrl #(.ADDR_W(AW), .READ_LAT(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready), .cmd_byte_i(b_cmd_byte),
      .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_data_o(b_rsp_data),
      .busy_o(b_busy), .err_o(b_err),
      .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
      .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
   );

   // SRAM models: rdata valid READ_LAT cycles after the strobe cycle, EE otherwise
   logic [7:0] mem_a [64];
   logic [7:0] pipe_a;
   logic [7:0] mem_b [64];
   logic [7:0] pipe_b [3];

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
   end

   always @(posedge clk) begin
      if (mem_en && mem_we) mem_a[mem_addr] <= mem_wdata;
      pipe_a <= (mem_en && !mem_we) ? mem_a[mem_addr] : 8'hEE;
      if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
      pipe_b[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : 8'hEE;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign mem_rdata   = pipe_a;
   assign b_mem_rdata = pipe_b[2];

   // Cycle counter and strobe monitors (sampled mid-cycle)
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   wr_addr[$], wr_data[$], wr_cyc[$], rd_addr[$], rd_cyc[$], b_rd_cyc[$];
   int   en_consec = 0;
   logic prev_en = 1'b0;

   always @(negedge clk) begin
      if (mem_en && mem_we) begin
         wr_addr.push_back(int'(mem_addr));
         wr_data.push_back(int'(mem_wdata));
         wr_cyc.push_back(cyc);
      end
      if (mem_en && !mem_we) begin
         rd_addr.push_back(int'(mem_addr));
         rd_cyc.push_back(cyc);
         if (prev_en) en_consec <= en_consec + 1;
      end
      prev_en <= mem_en;
      if (b_mem_en && !b_mem_we) b_rd_cyc.push_back(cyc);
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_logs();
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
      rd_addr.delete(); rd_cyc.delete();
   endtask

   // Present one byte and return at the negedge after it transfers
   task automatic send(input logic [7:0] b);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_byte  = b;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("cmd_ready_timeout", int'(cmd_ready), 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) chk("rsp_valid_timeout", int'(rsp_valid), 1);
   endtask

   task automatic recv(output logic [7:0] d);
      wait_rsp();
      d = rsp_data;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_valid_drop", int'(rsp_valid), 0);
   endtask

   typedef struct {
      logic [7:0] a_byte;
      logic [7:0] data;
      logic [7:0] exp_addr;
      logic [7:0] exp_rsp;
   } vec_t;

   initial begin
      vec_t       vecs[5];
      logic [7:0] d;
      logic [7:0] exp4 [4];
      logic [7:0] exp_wa [4];
      logic [7:0] seq6 [5];
      int         n0;
      int         n;

      vecs[0] = '{8'h05, 8'hA5, 8'h05, 8'hA5};
      vecs[1] = '{8'hC7, 8'h3C, 8'h07, 8'h3C};   // upper address bits ignored
      vecs[2] = '{8'h3F, 8'hFF, 8'h3F, 8'hFF};   // top of address space
      vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00};
      vecs[4] = '{8'h80, 8'h5A, 8'h00, 8'h5A};   // aliases to 0, overwrites
      exp4    = '{8'h11, 8'h22, 8'h33, 8'h44};
      exp_wa  = '{8'h3E, 8'h3F, 8'h00, 8'h01};
      seq6    = '{8'h40, 8'h22, 8'h9C, 8'h80, 8'h22};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready_low", int'(cmd_ready), 0);
      rst_n = 1'b1;
      #1;
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_mem_en", int'(mem_en), 0);
      @(negedge clk);

      // Single write then read, table driven
      for (int i = 0; i < 5; i++) begin
         clear_logs();
         send(8'h40); send(vecs[i].a_byte); send(vecs[i].data);
         send(8'h80); send(vecs[i].a_byte);
         n0 = cyc;
         wait_rsp();
         chk("vec_latency", cyc - n0, 3);
         recv(d);
         chk("vec_rsp_data", int'(d), int'(vecs[i].exp_rsp));
         chk("vec_wr_count", wr_addr.size(), 1);
         chk("vec_rd_count", rd_addr.size(), 1);
         if (wr_addr.size() > 0) begin
            chk("vec_wr_addr", wr_addr[0], int'(vecs[i].exp_addr));
            chk("vec_wr_data", wr_data[0], int'(vecs[i].data));
         end
         if (rd_addr.size() > 0) begin
            chk("vec_rd_addr", rd_addr[0], int'(vecs[i].exp_addr));
            chk("vec_rd_strobe_cyc", rd_cyc[0] - n0, 1);
         end
      end

      // Burst write len=3 wrapping past the top address
      clear_logs();
      send(8'h43); send(8'h3E);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      chk("burst_busy_final_strobe", int'(busy), 1);
      @(negedge clk);
      chk("burst_busy_after", int'(busy), 0);
      chk("burst_wr_count", wr_addr.size(), 4);
      if (wr_addr.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("burst_wr_addr", wr_addr[i], int'(exp_wa[i]));
            chk("burst_wr_data", wr_data[i], int'(exp4[i]));
            chk("burst_wr_consecutive", wr_cyc[i] - wr_cyc[0], i);
         end
      end

      // Burst read with response backpressure
      clear_logs();
      send(8'h83); send(8'h3E);
      wait_rsp();
      repeat (5) begin
         @(negedge clk);
         chk("bp_rsp_data_stable", int'(rsp_data), 8'h11);
         chk("bp_rsp_valid_held", int'(rsp_valid), 1);
      end
      chk("bp_no_extra_strobe", rd_addr.size(), 1);
      for (int i = 0; i < 4; i++) begin
         recv(d);
         chk("bp_rsp_order", int'(d), int'(exp4[i]));
      end
      chk("bp_rd_count", rd_addr.size(), 4);
      if (rd_addr.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("bp_rd_addr", rd_addr[i], int'(exp_wa[i]));
      end
      chk("rd_strobe_not_consecutive", en_consec, 0);

      // Reserved opcode then NOP
      clear_logs();
      send(8'hC0);
      chk("rsv_err_set", int'(err), 1);
      chk("rsv_busy", int'(busy), 0);
      send(8'h00);
      chk("nop_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      chk("rsv_err_sticky", int'(err), 1);
      chk("rsv_no_strobe", wr_addr.size() + rd_addr.size(), 0);
      send(8'h40); send(8'h10); send(8'h77);
      send(8'h80); send(8'h10);
      recv(d);
      chk("after_err_rd_data", int'(d), 8'h77);
      chk("after_err_still_set", int'(err), 1);

      // Asynchronous reset while a response is pending
      send(8'h80); send(8'h10);
      wait_rsp();
      rst_n = 1'b0;
      #1;
      chk("arst_rsp_valid", int'(rsp_valid), 0);
      chk("arst_mem_en", int'(mem_en), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_err", int'(err), 0);
      chk("arst_rsp_data", int'(rsp_data), 0);
      chk("arst_cmd_ready", int'(cmd_ready), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("arst_rel_cmd_ready", int'(cmd_ready), 1);
      chk("arst_rel_busy", int'(busy), 0);
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) n++;
      end
      chk("arst_read_discarded", n, 0);
      send(8'h80); send(8'h10);
      recv(d);
      chk("arst_then_read", int'(d), 8'h77);

      // READ_LAT = 3 instance: write 9C at 0x22, read it back
      for (int i = 0; i < 5; i++) begin
         b_cmd_valid = 1'b1;
         b_cmd_byte  = seq6[i];
         chk("lat3_cmd_ready", int'(b_cmd_ready), 1);
         @(negedge clk);
      end
      b_cmd_valid = 1'b0;
      n0 = cyc;
      n  = 0;
      while (!b_rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("lat3_rsp_valid", int'(b_rsp_valid), 1);
      chk("lat3_rsp_data", int'(b_rsp_data), 8'h9C);
      chk("lat3_latency", cyc - n0, 5);
      chk("lat3_rd_count", b_rd_cyc.size(), 1);
      if (b_rd_cyc.size() > 0) chk("lat3_strobe_to_valid", cyc - b_rd_cyc[0], 4);
      b_rsp_ready = 1'b1;
      @(negedge clk);
      b_rsp_ready = 1'b0;
      chk("lat3_rsp_drop", int'(b_rsp_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
`default_nettype wire
